hour_set_counter: RTL
=====================

// Module: hour_set_counter
// PURPOSE
//   Generates the BCD hour digits (tens, units) of the 24-hour digital clock.
//   Counts hours on a one-cycle tick from the minute stage. Provides a two-step
//   set mode, driven from two already-debounced buttons, that writes the hour
//   value. Its tens/units outputs drive the seven-segment digit decoders. It
//   also asserts a one-cycle pulse at midnight.
// PARAMETERS
//   BLINK_DIV  25_000_000  clk cycles per blink half-period while setting (>=2)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   rst          in   1  synchronous, active-high reset
//   tick_hr      in   1  one-cycle pulse: advance hour by one (minute 59->00)
//   btn_mode     in   1  debounced level; rising edge steps the set state
//   btn_up       in   1  debounced level; rising edge increments selected digit
//   hour_tens    out  4  BCD tens of hour, 0..2
//   hour_units   out  4  BCD units of hour, 0..9 (0..3 when tens==2)
//   day_pulse    out  1  one-cycle pulse when hour wraps 23->00 in RUN
//   setting      out  1  1 while in SET_TENS or SET_UNITS
//   blank_tens   out  1  1 = display should blank tens digit (blink)
//   blank_units  out  1  1 = display should blank units digit (blink)
// BEHAVIOUR
//   Reset (sync, rst=1 at rising edge):
//   - state=RUN; hour_tens=0, hour_units=0.
//   - day_pulse=0, setting=0, blank_*=0; blink counter=0, blink phase=0.
//   - Button edge registers are loaded with the current btn levels. A button
//     held through reset therefore gives no edge.
//   Edges: mode_e = btn_mode & ~btn_mode_q, and likewise up_e. Both are
//     registered one cycle; state/digit effect appears one cycle after the
//     edge cycle.
//   States: RUN -(mode_e)-> SET_TENS -(mode_e)-> SET_UNITS -(mode_e)-> RUN.
//   RUN:
//   - tick_hr=1: units+1. Units 9->0 with tens+1. 23->00 and day_pulse=1
//     for exactly the next cycle, coincident with the 00 display.
//   - up_e is ignored.
//   - tick_hr together with mode_e in the same cycle: the tick is applied
//     AND state goes to SET_TENS.
//   SET_TENS:
//   - up_e: tens 0->1->2->0.
//   - On entering tens==2 with units>3: units clamps to 3 in the same cycle.
//   - tick_hr is ignored (dropped, not queued).
//   SET_UNITS:
//   - up_e: units+1, wrapping to 0 after 9 (after 3 when tens==2).
//   - tick_hr is ignored.
//   mode_e together with up_e in the same cycle: the increment applies to the
//     digit of the current state, then the state advances.
//   Blink:
//   - Counter runs only while setting=1. It is cleared and phase=0 on every
//     state change.
//   - Phase toggles when the counter reaches BLINK_DIV-1; the counter then
//     returns to 0.
//   - blank_tens = (state==SET_TENS) & phase.
//   - blank_units = (state==SET_UNITS) & phase.
//   - Any up_e clears the counter and phase, so the digit shows immediately.
//   setting is registered: 1 from the cycle the state leaves RUN until the
//     cycle it re-enters RUN.
//   Outputs are registered; no combinational path from inputs to outputs.
//   Invariant: hour value is always 00..23. No illegal BCD code is ever
//     output, in any state or after reset mid-operation.
//   Reset asserted mid-set: returns to RUN 00 on the next edge. The digits
//     being set are discarded.
// TESTING
//   1. rst, then 23 tick_hr pulses -> 23:xx. One more tick -> hour 00 next
//      cycle, day_pulse=1 for exactly 1 cycle.
//   2. Hour=19, tick_hr -> 20 (units wrap 9->0, tens 1->2). No day_pulse.
//   3. Hour=18; mode_e; up_e -> tens=2, units clamped to 3 (23). Further up_e
//      -> tens=0, units=3.
//   4. SET_UNITS with tens=2, units=3; up_e -> units=0. mode_e -> RUN,
//      setting=0.
//   5. BLINK_DIV=4. Enter SET_TENS -> blank_tens toggles every 4 cycles,
//      blank_units=0. up_e -> blank_tens=0 and period restarts.
//   6. tick_hr during SET_* is dropped (hour unchanged). tick_hr with mode_e
//      in RUN -> hour+1 and SET_TENS. rst mid-SET_UNITS -> RUN, 00, all
//      flags 0.

Source files
------------

// File: rtl/hour_set_if.sv
// Hour-counter port bundle: tick/button inputs toward the counter, BCD digits and display flags back.
interface hour_set_if;
  logic       tick_hr;
  logic       btn_mode;
  logic       btn_up;
  logic [3:0] hour_tens;
  logic [3:0] hour_units;
  logic       day_pulse;
  logic       setting;
  logic       blank_tens;
  logic       blank_units;

  modport master (
    output tick_hr, btn_mode, btn_up,
    input  hour_tens, hour_units, day_pulse, setting, blank_tens, blank_units
  );

  modport slave (
    input  tick_hr, btn_mode, btn_up,
    output hour_tens, hour_units, day_pulse, setting, blank_tens, blank_units
  );
endinterface

// File: rtl/hour_set_counter.sv
// BCD 24-hour counter with a two-step button set mode, blink control and midnight pulse.
module hour_set_counter #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic      clk,
  input  logic      rst,
  hour_set_if.slave hs
);

  localparam int unsigned   CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_TENS  = 2'd1;
  localparam logic [1:0] ST_SET_UNITS = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             day_pulse_q, day_pulse_d;
  logic             setting_q, setting_d;
  logic             blank_tens_q, blank_tens_d;
  logic             blank_units_q, blank_units_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             btn_mode_q, btn_mode_d;
  logic             btn_up_q, btn_up_d;
  logic             mode_e_q, mode_e_d;
  logic             up_e_q, up_e_d;

  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    units_d       = units_q;
    day_pulse_d   = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    phase_d       = phase_q;
    btn_mode_d    = hs.btn_mode;
    btn_up_d      = hs.btn_up;
    mode_e_d      = hs.btn_mode & ~btn_mode_q;
    up_e_d        = hs.btn_up & ~btn_up_q;
    setting_d     = 1'b0;
    blank_tens_d  = 1'b0;
    blank_units_d = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // Ticks only count here; a coincident mode edge still takes the tick.
        if (hs.tick_hr) begin
          if (tens_q == 4'd2 && units_q >= 4'd3) begin
            tens_d      = 4'd0;
            units_d     = 4'd0;
            day_pulse_d = 1'b1;
          end else if (units_q >= 4'd9) begin
            units_d = 4'd0;
            tens_d  = tens_q + 4'd1;
          end else begin
            units_d = units_q + 4'd1;
          end
        end
        if (mode_e_q) state_d = ST_SET_TENS;
      end
      ST_SET_TENS: begin
        if (up_e_q) begin
          if (tens_q == 4'd0) begin
            tens_d = 4'd1;
          end else if (tens_q == 4'd1) begin
            tens_d = 4'd2;
            if (units_q > 4'd3) units_d = 4'd3;
          end else begin
            tens_d = 4'd0;
          end
        end
        if (mode_e_q) state_d = ST_SET_UNITS;
      end
      ST_SET_UNITS: begin
        if (up_e_q) begin
          if ((tens_q == 4'd2 && units_q >= 4'd3) || units_q >= 4'd9) units_d = 4'd0;
          else                                                        units_d = units_q + 4'd1;
        end
        if (mode_e_q) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        tens_d  = 4'd0;
        units_d = 4'd0;
      end
    endcase

    // Blink restarts on any state change or increment so the edited digit shows at once.
    if (state_q == ST_RUN || state_d != state_q || up_e_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
    end

    setting_d     = (state_d != ST_RUN);
    blank_tens_d  = (state_d == ST_SET_TENS) & phase_d;
    blank_units_d = (state_d == ST_SET_UNITS) & phase_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      tens_q        <= 4'd0;
      units_q       <= 4'd0;
      day_pulse_q   <= 1'b0;
      setting_q     <= 1'b0;
      blank_tens_q  <= 1'b0;
      blank_units_q <= 1'b0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      btn_mode_q    <= hs.btn_mode;
      btn_up_q      <= hs.btn_up;
      mode_e_q      <= 1'b0;
      up_e_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tens_q        <= tens_d;
      units_q       <= units_d;
      day_pulse_q   <= day_pulse_d;
      setting_q     <= setting_d;
      blank_tens_q  <= blank_tens_d;
      blank_units_q <= blank_units_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      btn_mode_q    <= btn_mode_d;
      btn_up_q      <= btn_up_d;
      mode_e_q      <= mode_e_d;
      up_e_q        <= up_e_d;
    end
  end

  assign hs.hour_tens   = tens_q;
  assign hs.hour_units  = units_q;
  assign hs.day_pulse   = day_pulse_q;
  assign hs.setting     = setting_q;
  assign hs.blank_tens  = blank_tens_q;
  assign hs.blank_units = blank_units_q;

endmodule
